// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: PC sequencing, one-cycle synchronous imem access,
// and a single-entry hold buffer that keeps the fetched word while decode stalls.
module instr_fetch_stage #(
  parameter int                   DataWidth        = 32,
  parameter int                   InstrCapacity    = 8192,
  parameter logic [DataWidth-1:0] InstrOffset      = 32'h00400000,
  parameter logic [DataWidth-1:0] ExceptionAddress = 32'h00000004,
  localparam int                  InstrAddrWidth   = $clog2(InstrCapacity)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      branch_valid,
  input  logic [DataWidth-1:0]      branch_target,
  input  logic                      exception,
  output logic [InstrAddrWidth-1:0] imem_addr,
  input  logic [DataWidth-1:0]      imem_rdata,
  output logic [DataWidth-1:0]      if_pc,
  output logic [DataWidth-1:0]      if_instr,
  output logic                      if_valid,
  output logic                      fetch_fault,
  output logic [DataWidth-1:0]      fault_addr
);

  typedef enum logic {LIVE, HELD} state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [DataWidth-1:0] r_pc;
  logic [DataWidth-1:0] w_pc_next;
  logic [DataWidth-1:0] r_f1_pc;
  logic                 r_f1_valid;
  logic [DataWidth-1:0] r_hold_instr;
  logic                 r_fetch_fault;
  logic [DataWidth-1:0] r_fault_addr;
  logic                 w_redirect;
  logic                 w_capture;
  logic                 w_misaligned;

  assign w_redirect   = exception | branch_valid;
  assign w_misaligned = branch_valid & ~exception & (|branch_target[1:0]);

  always_comb begin
    w_pc_next = r_pc;
    if (exception) begin
      w_pc_next = ExceptionAddress;
    end else if (branch_valid) begin
      w_pc_next = {branch_target[DataWidth-1:2], 2'b00};
    end else if (!stall) begin
      w_pc_next = r_pc + DataWidth'(4);
    end
  end

  // Capture happens only when a valid word would otherwise be lost to the stall.
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    case (r_state)
      LIVE: begin
        if (stall && r_f1_valid && !flush && !w_redirect) begin
          w_state_next = HELD;
          w_capture    = 1'b1;
        end
      end
      HELD: begin
        if (!stall || flush || w_redirect) begin
          w_state_next = LIVE;
        end
      end
      default: w_state_next = LIVE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= LIVE;
      r_pc          <= InstrOffset;
      r_f1_pc       <= '0;
      r_f1_valid    <= 1'b0;
      r_hold_instr  <= '0;
      r_fetch_fault <= 1'b0;
      r_fault_addr  <= '0;
    end else begin
      r_state       <= w_state_next;
      r_pc          <= w_pc_next;
      r_fetch_fault <= w_misaligned;
      if (w_misaligned) begin
        r_fault_addr <= branch_target;
      end
      if (w_capture) begin
        r_hold_instr <= imem_rdata;
      end
      if (w_redirect) begin
        r_f1_valid <= 1'b0;
      end else if (!stall) begin
        r_f1_pc    <= r_pc;
        r_f1_valid <= ~flush;
      end else if (flush) begin
        r_f1_valid <= 1'b0;
      end
    end
  end

  assign imem_addr   = r_pc[InstrAddrWidth+1:2];
  assign if_pc       = r_f1_pc;
  assign if_valid    = (r_state == HELD) | r_f1_valid;
  assign if_instr    = (r_state == HELD) ? r_hold_instr :
                       (r_f1_valid ? imem_rdata : '0);
  assign fetch_fault = r_fetch_fault;
  assign fault_addr  = r_fault_addr;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Scoreboard bench for instr_fetch_stage: a one-slot behavioural fetch model
// predicts every consumed instruction; a negedge monitor compares the DUT.
module tb_instr_fetch_stage;

  localparam logic [31:0] OFFS = 32'h00400000;
  localparam logic [31:0] EXC  = 32'h00000004;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0, flush = 1'b0, branch_valid = 1'b0, exception = 1'b0;
  logic [31:0] branch_target = '0;
  logic [12:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] if_pc, if_instr, fault_addr;
  logic        if_valid, fetch_fault;

  instr_fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .branch_valid(branch_valid), .branch_target(branch_target),
    .exception(exception), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .if_pc(if_pc), .if_instr(if_instr), .if_valid(if_valid),
    .fetch_fault(fetch_fault), .fault_addr(fault_addr)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [8192];
  always @(posedge clk) imem_rdata <= mem[imem_addr];

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } item_t;
  item_t sb_q[$];
  item_t mon_item;

  // Reference: fetch address plus one output slot holding the address it came from.
  logic [31:0] m_pc;
  logic        m_slot_v;
  logic [31:0] m_slot_pc;
  logic        m_fault;
  logic [31:0] m_fault_addr;

  function automatic logic [12:0] word_of(input logic [31:0] a);
    return a[14:2];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = OFFS;
    m_slot_v = 1'b0;
    m_slot_pc = '0;
    m_fault = 1'b0;
    m_fault_addr = '0;
  endtask

  // Called at posedge+1; drives one cycle of inputs and advances the model at the edge.
  task automatic cycle(input logic st, input logic fl, input logic br,
                       input logic [31:0] bt, input logic ex);
    item_t it;
    stall = st; flush = fl; branch_valid = br; branch_target = bt; exception = ex;
    if (m_slot_v && !st && !fl && !br && !ex) begin
      it.pc = m_slot_pc;
      it.instr = mem[word_of(m_slot_pc)];
      sb_q.push_back(it);
    end
    @(posedge clk);
    m_fault = br && !ex && (bt[1:0] != 2'b00);
    if (m_fault) m_fault_addr = bt;
    if (ex) begin
      m_pc = EXC; m_slot_v = 1'b0;
    end else if (br) begin
      m_pc = {bt[31:2], 2'b00}; m_slot_v = 1'b0;
    end else if (fl) begin
      m_slot_v = 1'b0;
      if (!st) m_pc = m_pc + 32'd4;
    end else if (!st) begin
      m_slot_v = 1'b1; m_slot_pc = m_pc; m_pc = m_pc + 32'd4;
    end
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      check("if_valid", 32'(if_valid), 32'(m_slot_v));
      check("imem_addr", 32'(imem_addr), 32'(word_of(m_pc)));
      check("fetch_fault", 32'(fetch_fault), 32'(m_fault));
      check("fault_addr", fault_addr, m_fault_addr);
      if (!if_valid) check("idle_instr", if_instr, 32'h0);
      if (if_valid && !stall && !flush && !branch_valid && !exception) begin
        if (sb_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_transfer: got pc %h instr %h expected none", if_pc, if_instr);
        end else begin
          mon_item = sb_q.pop_front();
          $display("xfer pc=%h instr=%h", if_pc, if_instr);
          check("xfer_pc", if_pc, mon_item.pc);
          check("xfer_instr", if_instr, mon_item.instr);
        end
      end
    end
  end

  initial begin
    for (int k = 0; k < 8192; k++) mem[k] = k;
    model_reset();
    #1 reset = 1'b1;
    #2;
    check("rst_if_valid", 32'(if_valid), 32'h0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_if_instr", if_instr, 32'h0);
    check("rst_imem_addr", 32'(imem_addr), 32'h0);
    check("rst_fetch_fault", 32'(fetch_fault), 32'h0);
    check("rst_fault_addr", fault_addr, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Sequential fetch from the reset PC
    check("first_addr", 32'(imem_addr), 32'h0);
    check("first_valid", 32'(if_valid), 32'h0);
    cycle(0, 0, 0, 0, 0);
    check("seq0_pc", if_pc, 32'h00400000);
    check("seq0_instr", if_instr, 32'd0);
    cycle(0, 0, 0, 0, 0);
    check("seq1_pc", if_pc, 32'h00400004);
    check("seq1_instr", if_instr, 32'd1);

    // Three-cycle stall on 0x00400004
    for (int i = 0; i < 3; i++) begin
      check("stall_instr", if_instr, 32'd1);
      check("stall_addr", 32'(imem_addr), 32'd2);
      cycle(1, 0, 0, 0, 0);
    end
    check("release_instr", if_instr, 32'd1);
    cycle(0, 0, 0, 0, 0);
    check("after_stall_pc", if_pc, 32'h00400008);
    check("after_stall_instr", if_instr, 32'd2);

    // Aligned branch
    cycle(0, 0, 1, 32'h00400100, 0);
    check("br_bubble", 32'(if_valid), 32'h0);
    check("br_addr", 32'(imem_addr), 32'd64);
    cycle(0, 0, 0, 0, 0);
    check("br_pc", if_pc, 32'h00400100);
    check("br_instr", if_instr, 32'd64);

    // Exception together with branch during a held stall
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 1, 32'h00400200, 1);
    check("exc_drop_held", 32'(if_valid), 32'h0);
    check("exc_addr", 32'(imem_addr), 32'd1);
    cycle(0, 0, 0, 0, 0);
    check("exc_pc", if_pc, 32'h00000004);

    // Misaligned branch target
    cycle(0, 0, 1, 32'h00400102, 0);
    check("fault_pulse", 32'(fetch_fault), 32'h1);
    check("fault_value", fault_addr, 32'h00400102);
    cycle(0, 0, 0, 0, 0);
    check("fault_clear", 32'(fetch_fault), 32'h0);
    check("fault_hold", fault_addr, 32'h00400102);
    check("fault_resume_pc", if_pc, 32'h00400100);

    // PC wrap past 2^32
    cycle(0, 0, 1, 32'hFFFFFFF8, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0);

    // Asynchronous reset between edges while holding
    cycle(1, 0, 0, 0, 0);
    check("pre_reset_valid", 32'(if_valid), 32'h1);
    #3 reset = 1'b1;
    #1;
    check("async_rst_valid", 32'(if_valid), 32'h0);
    check("async_rst_addr", 32'(imem_addr), 32'h0);
    check("async_rst_pc", if_pc, 32'h0);
    stall = 0; flush = 0; branch_valid = 0; exception = 0; branch_target = '0;
    model_reset();
    for (int k = 0; k < 8192; k++) mem[k] = $urandom;
    @(posedge clk); #1;
    reset = 1'b0;

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      logic [31:0] bt;
      bt = $urandom;
      if ($urandom_range(0, 3) != 0) bt[1:0] = 2'b00;
      cycle($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 8,
            $urandom_range(0, 99) < 8, bt, $urandom_range(0, 99) < 3);
    end
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0);
    check("scoreboard_drain", 32'(sb_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_fetch_stage.md
INSTR_FETCH_STAGE -- requirements
Module: instr_fetch_stage

Interface
REQ-001 Parameter DataWidth, default 32, SHALL set the width of the PC, instruction, target and address outputs.
REQ-002 Parameter InstrCapacity, default 8192, SHALL set the instruction memory depth in words; InstrAddrWidth = ceil(log2(InstrCapacity)) = 13.
REQ-003 Parameter InstrOffset, default 32'h00400000, SHALL be the reset PC.
REQ-004 Parameter ExceptionAddress, default 32'h00000004, SHALL be the exception vector.
REQ-005 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-006 Port reset, input, 1: asynchronous, active-high reset.
REQ-007 Port stall, input, 1: downstream cannot accept the current fetch output.
REQ-008 Port flush, input, 1: discard the current and in-flight fetch.
REQ-009 Port branch_valid, input, 1: redirect request.
REQ-010 Port branch_target, input, 32: redirect address.
REQ-011 Port exception, input, 1: redirect to ExceptionAddress.
REQ-012 Port imem_addr, output, InstrAddrWidth: word index to synchronous instruction memory.
REQ-013 Port imem_rdata, input, 32: memory data, valid one cycle after the address.
REQ-014 Ports if_pc (32), if_instr (32), if_valid (1), outputs: fetched instruction toward decode.
REQ-015 Ports fetch_fault (1), fault_addr (32), outputs: misaligned-target report.

Function
REQ-016 The block SHALL hold a PC register; imem_addr SHALL equal PC[InstrAddrWidth+1:2] combinationally, so that 0x00400000 maps to index 0 and 0x00000004 to index 1.
REQ-017 An in-flight register (f1_pc, f1_valid) SHALL record the address whose data arrives on imem_rdata in the current cycle.
REQ-018 Next-PC priority SHALL be: exception -> ExceptionAddress; else branch_valid -> {branch_target[31:2],2'b00}; else stall -> hold PC; else PC+4, wrapping modulo 2^32.
REQ-019 Exception and branch_valid SHALL override stall.
REQ-020 On a redirect edge, f1_valid SHALL be cleared and the HELD buffer SHALL be emptied.
REQ-021 When not stalled and not redirecting, the block SHALL advance: f1_pc <= PC and f1_valid <= !flush.
REQ-022 The output source FSM SHALL have states LIVE and HELD.
- LIVE: if_instr = imem_rdata, if_pc = f1_pc, if_valid = f1_valid.
- LIVE -> HELD when stall && f1_valid && !flush && !redirect; the block SHALL capture imem_rdata into hold_instr.
- HELD: if_instr = hold_instr, if_valid = 1, and the PC/f1 registers SHALL NOT change.
- HELD -> LIVE when !stall (the instruction is consumed that cycle), or on flush or redirect (the instruction is discarded).
REQ-023 Flush without a redirect SHALL clear f1_valid and HELD while the PC still follows REQ-018.
REQ-024 If if_valid = 0, if_instr SHALL be 32'h00000000.
REQ-025 On a branch_valid edge with branch_target[1:0] != 0 and no exception, the block SHALL set fetch_fault = 1 for exactly the next cycle, with fault_addr = the unaligned branch_target; at other times fetch_fault SHALL be 0 and fault_addr SHALL hold its last value.
REQ-026 Fetch latency SHALL be one cycle: an address presented in cycle N SHALL produce a valid if_instr in cycle N+1, absent stall, flush or redirect.
REQ-027 Simultaneous flush and redirect SHALL behave as the redirect alone.

Reset
REQ-028 While reset = 1, the block SHALL hold: PC = InstrOffset, imem_addr = 0, f1_valid = 0, state = LIVE, hold_instr = 0, if_valid = 0, if_pc = 0, if_instr = 0, fetch_fault = 0, fault_addr = 0, independent of clk.
REQ-029 Reset asserted mid-stall or mid-HELD SHALL discard the held instruction with no output pulse.
REQ-030 In the first cycle after reset release, imem_addr SHALL be 0; the first if_valid SHALL occur one cycle later with if_pc = 32'h00400000.

Verification
REQ-031 Sequential fetch: release reset, memory word k = k, no stall -> if_pc 0x00400000, 0x00400004, 0x00400008 with if_instr 0, 1, 2 on consecutive cycles.
REQ-032 Stall for 3 cycles while if_pc = 0x00400004 -> if_instr = 1 held for 3 cycles; imem_addr stays 2; after release, 0x00400008 / 2 follows with no gap or duplicate.
REQ-033 branch_valid with target 0x00400100 -> the next cycle has if_valid = 0; the following cycle has if_pc = 0x00400100 and imem_addr 64 was issued.
REQ-034 exception and branch_valid asserted together during a stall -> PC = 0x00000004; HELD is dropped; if_pc = 0x00000004 two cycles later.
REQ-035 branch_target = 0x00400102 -> fetch_fault pulses for 1 cycle with fault_addr = 0x00400102; the fetch resumes at 0x00400100.
REQ-036 Asynchronous reset asserted between clock edges while in HELD -> if_valid = 0 immediately; PC = 0x00400000.
